// File: rtl/vga_scanout.sv
// vga_scanout: pops RGB565 pixels from the scanline FIFO and drives VGA timing, trigger and underrun stats.
// Optional VGA_FLUSH_EN: drains stale FIFO pixels during vertical blanking, stopping one line before trigger.
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int TRIG_LINES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  output logic        fifo_read,
  input  logic [15:0] fifo_data,
  output logic        trigger,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [4:0]  r,
  output logic [5:0]  g,
  output logic [4:0]  b,
  output logic        underrun,
  output logic [15:0] underrun_cnt
);

  localparam int H_TOT_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOT_I - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOT_I - 1);
  localparam logic [10:0] H_ACT        = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT        = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_TRIG       = 11'(V_TOT_I - TRIG_LINES);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;

  logic active0;
  logic pop_pixel;
  logic miss0;

  logic de1;
  logic hs1;
  logic vs1;
  logic hit1;
  logic miss1;
  logic armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST)
        v_cnt <= '0;
      else
        v_cnt <= v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign active0   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign pop_pixel = active0 && !fifo_empty;
  assign miss0     = active0 && fifo_empty;

  // The pop request is combinational, so it is gated by rst to stay low while reset holds (0,0).
`ifdef VGA_FLUSH_EN
  logic flush_win;
  assign flush_win = (v_cnt >= V_ACT) && (v_cnt < V_TRIG);
  assign fifo_read = !rst && (pop_pixel || (flush_win && !fifo_empty));
`else
  assign fifo_read = !rst && pop_pixel;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de1   <= 1'b0;
      hs1   <= 1'b1;
      vs1   <= 1'b1;
      hit1  <= 1'b0;
      miss1 <= 1'b0;
    end else begin
      de1   <= active0;
      hs1   <= !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
      vs1   <= !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
      hit1  <= pop_pixel;
      miss1 <= miss0;
    end
  end

  // Flush pops never set hit1, so discarded pixels are never shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de           <= 1'b0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      r            <= '0;
      g            <= '0;
      b            <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      de       <= de1;
      hsync    <= hs1;
      vsync    <= vs1;
      underrun <= miss1;
      if (hit1)
        {r, g, b} <= fifo_data;
      else
        {r, g, b} <= '0;
      if (miss1 && (underrun_cnt != 16'hFFFF))
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed   <= 1'b0;
      trigger <= 1'b0;
    end else begin
      armed   <= 1'b1;
      trigger <= armed && (h_cnt == '0) && (v_cnt == V_TRIG);
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: drives a queue-backed pixel FIFO into vga_scanout and checks every cycle against a raster model.
// Uses a reduced raster so several whole frames fit in a short run; honours VGA_FLUSH_EN when defined.
module tb_vga_scanout;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int TL = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic        fifo_read;
  logic [15:0] fifo_data = '0;
  logic        trigger, hsync, vsync, de, underrun;
  logic [4:0]  r;
  logic [5:0]  g;
  logic [4:0]  b;
  logic [15:0] underrun_cnt;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .TRIG_LINES(TL)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .fifo_data(fifo_data), .trigger(trigger), .hsync(hsync), .vsync(vsync),
    .de(de), .r(r), .g(g), .b(b), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        de;
    logic        hs;
    logic        vs;
    logic [15:0] px;
    logic        und;
    logic [15:0] cnt;
  } exp_t;

  logic [15:0] fifo_q[$];
  logic [15:0] mdl_q[$];
  exp_t        exp_q[$];

  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  int          mode = 1;
  bit          force_on = 0;
  logic [15:0] next_val = '0;
  logic [15:0] mdl_cnt = '0;
  logic        trig_exp = 1'b0;
  int          trig_count = 0;
  int          hs_fall_k = -1;
  int          de_rise_k = -1;
  logic        prev_hs = 1'b1, prev_de = 1'b0, prev_trig = 1'b0;
  logic [15:0] first_px = '0;
  logic [15:0] lead = '0;

  // FIFO read port: data appears the cycle after a pop.
  always @(posedge clk) begin
    if (fifo_read && fifo_q.size() > 0)
      fifo_data <= fifo_q.pop_front();
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at k=%0d actual=%0h required=%0h", name, k, act, req);
    end
  endtask

  task automatic push_px(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_val);
      mdl_q.push_back(next_val);
      next_val++;
    end
  endtask

  task automatic applyStimulus(input int ph, input int pv);
    if (mode == 1)
      while (fifo_q.size() < 2) push_px(1);
    fifo_empty = (force_on && pv == 5 && ph >= 8 && ph <= 11) || (fifo_q.size() == 0);
  endtask

  task automatic checkOutput(input logic rd);
    exp_t e;
    e = exp_q.pop_front();
    cmp("fifo_read", 32'(fifo_read), 32'(rd));
    cmp("de", 32'(de), 32'(e.de));
    cmp("hsync", 32'(hsync), 32'(e.hs));
    cmp("vsync", 32'(vsync), 32'(e.vs));
    cmp("rgb", 32'({r, g, b}), 32'(e.px));
    cmp("underrun", 32'(underrun), 32'(e.und));
    cmp("underrun_cnt", 32'(underrun_cnt), 32'(e.cnt));
    cmp("trigger", 32'(trigger), 32'(trig_exp));
    if (prev_hs && !hsync && hs_fall_k < 0) hs_fall_k = k;
    if (!prev_de && de && de_rise_k < 0) begin
      de_rise_k = k;
      first_px  = {r, g, b};
    end
    if (trigger && !prev_trig) trig_count++;
    prev_hs   = hsync;
    prev_de   = de;
    prev_trig = trigger;
  endtask

  // Raster position is pure arithmetic on cycles since release; outputs are due two cycles later.
  task automatic cycle_proc();
    int          ph, pv;
    bit          act, flush, rd;
    logic [15:0] popped;
    exp_t        e;
    ph = k % HT;
    pv = (k / HT) % VT;
    applyStimulus(ph, pv);
    #1;
    act   = (ph < HA) && (pv < VA);
    flush = 0;
`ifdef VGA_FLUSH_EN
    flush = (pv >= VA) && (pv < VT - TL);
`endif
    rd    = (act || flush) && !fifo_empty;
    e.de  = act;
    e.hs  = !((ph >= HA + HF) && (ph < HA + HF + HS));
    e.vs  = !((pv >= VA + VF) && (pv < VA + VF + VS));
    e.px  = '0;
    if (rd) begin
      popped = (mdl_q.size() > 0) ? mdl_q.pop_front() : 16'hDEAD;
      if (act) e.px = popped;
    end
    e.und = act && fifo_empty;
    if (e.und && mdl_cnt != 16'hFFFF) mdl_cnt++;
    e.cnt = mdl_cnt;
    exp_q.push_back(e);
    checkOutput(rd);
    trig_exp = (ph == 0) && (pv == VT - TL);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    cycle_proc();
  endtask

  task automatic run_to(input int n);
    while (k < n) step();
  endtask

  task automatic check_reset();
    cmp("rst_fifo_read", 32'(fifo_read), 32'd0);
    cmp("rst_trigger", 32'(trigger), 32'd0);
    cmp("rst_hsync", 32'(hsync), 32'd1);
    cmp("rst_vsync", 32'(vsync), 32'd1);
    cmp("rst_de", 32'(de), 32'd0);
    cmp("rst_rgb", 32'({r, g, b}), 32'd0);
    cmp("rst_underrun", 32'(underrun), 32'd0);
    cmp("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
  endtask

  task automatic release_reset();
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    k   = 0;
    e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.px = '0; e.und = 1'b0; e.cnt = '0;
    exp_q.delete();
    exp_q.push_back(e);
    exp_q.push_back(e);
    mdl_q = fifo_q;
    mdl_cnt   = '0;
    trig_exp  = 1'b0;
    prev_hs   = 1'b1;
    prev_de   = 1'b0;
    prev_trig = 1'b0;
    hs_fall_k = -1;
    de_rise_k = -1;
    trig_count = 0;
    cycle_proc();
  endtask

  initial begin
    repeat (3) begin
      @(posedge clk);
      #2;
      check_reset();
    end
    release_reset();

    // Frame 1: pixels 8..11 of line 5 see an empty FIFO.
    force_on = 1;
    run_to(100);
    cmp("first_hsync_fall", 32'(hs_fall_k), 32'(HA + HF + 2));
    cmp("first_de_rise", 32'(de_rise_k), 32'd2);
    cmp("first_pixel", 32'(first_px), 32'h0000);
    run_to(FR);
    force_on = 0;
    cmp("underrun_cnt_frame1", 32'(underrun_cnt), 32'd4);

    // From frame 3's trigger line, supply one frame plus 10 surplus pixels.
    run_to(2 * FR + (VT - TL) * HT);
    mode = 0;
    push_px(HA * VA + 10 - fifo_q.size());
    run_to(3 * FR);
    cmp("trigger_count_3_frames", 32'(trig_count), 32'd3);

    run_to(3 * FR + (VT - TL) * HT);
`ifdef VGA_FLUSH_EN
    cmp("leftover_at_trigger_line", 32'(fifo_q.size()), 32'd0);
`else
    cmp("leftover_at_trigger_line", 32'(fifo_q.size()), 32'd10);
`endif
    cmp("underrun_cnt_after_vblank", 32'(underrun_cnt), 32'd4);
    push_px(HA * VA);
    lead = fifo_q[0];
    run_to(4 * FR + 2);
    cmp("frame5_first_de", 32'(de), 32'd1);
    cmp("frame5_first_pixel", 32'({r, g, b}), 32'(lead));

    // Mid-frame asynchronous reset at (12,4).
    run_to(5 * FR);
    mode = 1;
    run_to(5 * FR + 4 * HT + 12);
    #1;
    rst = 1'b1;
    #1;
    check_reset();
    repeat (3) begin
      @(posedge clk);
      #2;
      check_reset();
    end
    release_reset();
    run_to(100);
    cmp("hsync_fall_after_reset", 32'(hs_fall_k), 32'(HA + HF + 2));
    run_to(FR + 10);
    cmp("trigger_count_after_reset", 32'(trig_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
